// File: rtl/uart_tx.sv
// uart_tx: one-bit-per-clock asynchronous serial transmitter
// (start, LSB-first data, optional even/odd parity, stop).
module uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_out,
   output logic                  busy
);
   localparam int CW = $clog2(DATA_WIDTH);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
   logic                  tx_q, tx_d, busy_q, busy_d;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end
   // tx_d/busy_d describe the line level for the state being entered
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (data_valid) begin
               data_d    = p_data;
               par_en_d  = par_en;
               par_typ_d = par_typ;
               state_d   = START;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
            end
         end
         START: begin
            state_d = DATA;
            cnt_d   = '0;
            tx_d    = data_q[0];
         end
         DATA: begin
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = par_en_q ? PARITY : STOP;
               tx_d    = par_en_q ? (^data_q) ^ par_typ_q : 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               tx_d  = data_q[cnt_d];
            end
         end
         PARITY: begin
            state_d = STOP;
            tx_d    = 1'b1;
         end
         STOP: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end
   assign tx_out = tx_q;
   assign busy   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and randomized frame checks for uart_tx against a
// frame-level reference model and a behavioural loopback receiver.
module tb_uart_tx;
   logic       clk = 1'b0, rst = 1'b1, data_valid = 1'b0, par_en = 1'b0, par_typ = 1'b0;
   logic [7:0] p_data = 8'h00;
   logic       tx_out, busy;
   int         total = 0, bad = 0;

   uart_tx #(.DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
      .par_en(par_en), .par_typ(par_typ), .tx_out(tx_out), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      bit         pe;
      bit         pt;
      int         len;
      int         par;
   } vec_t;
   vec_t vt[8];

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Frame as a list of line levels: start, data LSB first, parity, stop.
   function automatic int model_frame(input logic [7:0] d, input bit pe, input bit pt,
                                      output logic f[16]);
      int n;
      f = '{default: 1'b1};
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
      n = 9;
      if (pe) begin
         f[n] = (($countones(d) + int'(pt)) % 2) == 1;
         n++;
      end
      f[n] = 1'b1;
      return n + 1;
   endfunction

   task automatic run_frame(input logic [7:0] d, input bit pe, input bit pt,
                            input int exp_len, input int exp_par, input string nm);
      logic       got[32];
      logic       f[16];
      logic [7:0] w;
      int         n = 0, m, diff = 0, perr;
      @(negedge clk);
      p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0; p_data = ~d; par_en = ~pe; par_typ = ~pt;
      while (busy === 1'b1 && n < 32) begin
         got[n] = tx_out;
         n++;
         @(negedge clk);
      end
      check({nm, " len"}, n, exp_len);
      m = model_frame(d, pe, pt, f);
      for (int i = 0; i < m; i++) if (i >= n || got[i] !== f[i]) diff++;
      check({nm, " bits"}, diff, 0);
      if (pe) check({nm, " parity"}, int'(got[9] === 1'b1), exp_par);
      for (int i = 0; i < 8; i++) w[i] = got[i+1];
      check({nm, " rx data"}, int'(w), int'(d));
      check({nm, " rx stop"}, int'(n > 0 && got[n > 0 ? n-1 : 0] === 1'b1), 1);
      perr = pe ? int'((($countones(w) + int'(got[9] === 1'b1)) % 2) != int'(pt)) : 0;
      check({nm, " rx parity err"}, perr, 0);
      check({nm, " idle tx"}, int'(tx_out === 1'b1), 1);
   endtask

   initial begin
      logic f1[16], f2[16];
      int   diff, lows, n, len;
      logic [7:0] d;
      bit   pe, pt;

      vt[0] = '{8'hA5, 1'b0, 1'b0, 10, 0};
      vt[1] = '{8'hA5, 1'b1, 1'b0, 11, 0};
      vt[2] = '{8'hA5, 1'b1, 1'b1, 11, 1};
      vt[3] = '{8'h00, 1'b1, 1'b1, 11, 1};
      vt[4] = '{8'hFF, 1'b1, 1'b0, 11, 0};
      vt[5] = '{8'hFF, 1'b1, 1'b1, 11, 1};
      vt[6] = '{8'h01, 1'b1, 1'b0, 11, 1};
      vt[7] = '{8'h80, 1'b1, 1'b1, 11, 0};

      #1 rst = 1'b0;
      #2;
      check("reset tx", int'(tx_out === 1'b1), 1);
      check("reset busy", int'(busy === 1'b0), 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 8; i++)
         run_frame(vt[i].d, vt[i].pe, vt[i].pt, vt[i].len, vt[i].par, $sformatf("vec%0d", i));

      for (int i = 0; i < 30; i++) begin
         d  = 8'($urandom_range(0, 255));
         pe = 1'($urandom_range(0, 1));
         pt = 1'($urandom_range(0, 1));
         len = pe ? 11 : 10;
         run_frame(d, pe, pt, len, ($countones(d) + int'(pt)) % 2, $sformatf("rnd%0d", i));
      end

      // data_valid held high across two frames, p_data changed mid-frame
      void'(model_frame(8'h3C, 1'b0, 1'b0, f1));
      void'(model_frame(8'hC3, 1'b0, 1'b0, f2));
      @(negedge clk);
      p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
      @(negedge clk);
      p_data = 8'hC3;
      diff = 0; lows = 0;
      for (int i = 0; i < 21; i++) begin
         if (tx_out !== (i < 10 ? f1[i] : (i == 10 ? 1'b1 : f2[i-11]))) diff++;
         if (busy !== (i != 10)) diff++;
         if (busy === 1'b0) lows++;
         if (i == 20) data_valid = 1'b0;
         @(negedge clk);
      end
      check("b2b sequence", diff, 0);
      check("b2b idle cycles", lows, 1);
      check("b2b after idle", int'(busy === 1'b0 && tx_out === 1'b1), 1);

      // asynchronous reset in the middle of data bit 4 of an all-zero frame
      @(negedge clk);
      p_data = 8'h00; par_en = 1'b0; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("pre-reset bit4", int'(tx_out === 1'b0 && busy === 1'b1), 1);
      #1 rst = 1'b0;
      #1;
      check("async reset tx", int'(tx_out === 1'b1), 1);
      check("async reset busy", int'(busy === 1'b0), 1);
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (tx_out !== 1'b1 || busy !== 1'b0) n++;
      end
      check("no residual bits", n, 0);
      run_frame(8'h5A, 1'b1, 1'b0, 11, 0, "post-reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
